// File: rtl/decoder_3to8_if.sv
// Select/enable bundle and decoded outputs of the registered 3-to-8 decoder.
// The master drives select and enable; the slave returns flopped lines and flags.
interface decoder_3to8_if;
  logic a;
  logic b;
  logic c;
  logic en;
  logic y0;
  logic y1;
  logic y2;
  logic y3;
  logic y4;
  logic y5;
  logic y6;
  logic y7;
  logic valid;
  logic changed;

  modport master (
    output a, b, c, en,
    input  y0, y1, y2, y3,
    input  y4, y5, y6, y7,
    input  valid, changed
  );

  modport slave (
    input  a, b, c, en,
    output y0, y1, y2, y3,
    output y4, y5, y6, y7,
    output valid, changed
  );
endinterface

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 decoder with enable, valid flag and change-detect pulse.
// Lines are kept active-high internally; polarity is applied at the pins.
module decoder_3to8 #(
  parameter bit ACTIVE_LOW_OUT = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_3to8_if.slave  bus
);

  logic [2:0] sel;
  logic [7:0] hot_d;
  logic       chg_d;

  logic [7:0] hot_q;
  logic       valid_q;
  logic       changed_q;
  logic [2:0] prev_q;
  logic       none_q;

  logic [7:0] y_pins;

  assign sel = {bus.a, bus.b, bus.c};

  always_comb begin
    hot_d = 8'h00;
    unique case (sel)
      3'd0: hot_d = 8'h01;
      3'd1: hot_d = 8'h02;
      3'd2: hot_d = 8'h04;
      3'd3: hot_d = 8'h08;
      3'd4: hot_d = 8'h10;
      3'd5: hot_d = 8'h20;
      3'd6: hot_d = 8'h40;
      3'd7: hot_d = 8'h80;
      default: hot_d = 8'h00;
    endcase
  end

  // First enabled decode after reset always reports a change.
  assign chg_d = none_q | (sel != prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hot_q     <= 8'h00;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      prev_q    <= 3'd0;
      none_q    <= 1'b1;
    end else if (bus.en) begin
      hot_q     <= hot_d;
      valid_q   <= 1'b1;
      changed_q <= chg_d;
      prev_q    <= sel;
      none_q    <= 1'b0;
    end else begin
      hot_q     <= 8'h00;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end
  end

  assign y_pins = ACTIVE_LOW_OUT ? ~hot_q : hot_q;

  assign bus.y0      = y_pins[0];
  assign bus.y1      = y_pins[1];
  assign bus.y2      = y_pins[2];
  assign bus.y3      = y_pins[3];
  assign bus.y4      = y_pins[4];
  assign bus.y5      = y_pins[5];
  assign bus.y6      = y_pins[6];
  assign bus.y7      = y_pins[7];
  assign bus.valid   = valid_q;
  assign bus.changed = changed_q;

endmodule

// File: tb/tb_decoder_3to8.sv
// Scoreboard bench for decoder_3to8: both output polarities driven in lockstep.
// Driver queues hand-computed results; monitor pops one per clock.
module tb_decoder_3to8;

  logic clk;
  logic rst_n;

  decoder_3to8_if bus_h ();
  decoder_3to8_if bus_l ();

  decoder_3to8 #(.ACTIVE_LOW_OUT(1'b0)) dut_h (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_h)
  );

  decoder_3to8 #(.ACTIVE_LOW_OUT(1'b1)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l)
  );

  typedef struct {
    logic [2:0] idx;
    logic       v;
    logic       ch;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pack_h();
    return {bus_h.y7, bus_h.y6, bus_h.y5, bus_h.y4,
            bus_h.y3, bus_h.y2, bus_h.y1, bus_h.y0};
  endfunction

  function automatic logic [7:0] pack_l();
    return {bus_l.y7, bus_l.y6, bus_l.y5, bus_l.y4,
            bus_l.y3, bus_l.y2, bus_l.y1, bus_l.y0};
  endfunction

  task automatic check(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic check_all(string tag, logic [2:0] idx, logic v, logic ch);
    logic [7:0] hot;
    hot = v ? (8'h01 << idx) : 8'h00;
    check({tag, "_y_hi"},  pack_h(), hot);
    check({tag, "_y_lo"},  pack_l(), ~hot);
    check({tag, "_v_hi"},  {7'd0, bus_h.valid}, {7'd0, v});
    check({tag, "_v_lo"},  {7'd0, bus_l.valid}, {7'd0, v});
    check({tag, "_ch_hi"}, {7'd0, bus_h.changed}, {7'd0, ch});
    check({tag, "_ch_lo"}, {7'd0, bus_l.changed}, {7'd0, ch});
  endtask

  // One clock of stimulus plus the hand-computed result after the next edge.
  task automatic step(string tag, logic rst, logic [2:0] s, logic e,
                      logic ev, logic ech);
    exp_t x;
    @(negedge clk);
    rst_n = rst;
    {bus_h.a, bus_h.b, bus_h.c} = s;
    {bus_l.a, bus_l.b, bus_l.c} = s;
    bus_h.en = e;
    bus_l.en = e;
    x.idx = s;
    x.v   = ev;
    x.ch  = ech;
    x.tag = tag;
    sbq.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        check_all(x.tag, x.idx, x.v, x.ch);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst_n = 1'b0;
    {bus_h.a, bus_h.b, bus_h.c, bus_h.en} = 4'b1111;
    {bus_l.a, bus_l.b, bus_l.c, bus_l.en} = 4'b1111;

    for (int i = 0; i < 3; i++)
      step("rst", 1'b0, 3'd7, 1'b1, 1'b0, 1'b0);
    step("rel", 1'b1, 3'd7, 1'b1, 1'b1, 1'b1);

    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 10; k++)
        step("sweep", 1'b1, 3'(n), 1'b1, 1'b1, k == 0);

    step("en_on",  1'b1, 3'd5, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step("en_off", 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    step("en_back", 1'b1, 3'd5, 1'b1, 1'b1, 1'b0);

    step("pre_rst", 1'b1, 3'd3, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async", 3'd3, 1'b0, 1'b0);
    step("in_rst", 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    step("post_rst", 1'b1, 3'd3, 1'b1, 1'b1, 1'b1);

    for (int k = 0; k < 5; k++)
      step("hold", 1'b1, 3'd6, 1'b1, 1'b1, k == 0);

    step("gap", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    step("gap_new", 1'b1, 3'd1, 1'b1, 1'b1, 1'b1);
    step("gap_same", 1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
    step("idle", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("sb_drain", 8'(sbq.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
